// File: rtl/quad_decoder_if.sv
// Quadrature encoder bundle: raw pins in, debounced phase and step pulses out.
interface quad_decoder_if;
    logic       a;
    logic       b;
    logic       step_cw;
    logic       step_ccw;
    logic       err;
    logic [1:0] ab_db;

    modport master (output a, b, input step_cw, step_ccw, err, ab_db);
    modport slave  (input a, b, output step_cw, step_ccw, err, ab_db);
endinterface

// File: rtl/quad_decoder.sv
// Quadrature front end: per-pin synchroniser and debouncer, Gray-phase decode,
// sub-step accumulation into one-cycle cw/ccw/err pulses.
module quad_decoder #(
    parameter int unsigned DEBOUNCE_N      = 14,
    parameter int unsigned STEPS_PER_PULSE = 4
) (
    input  logic           clk,
    input  logic           rst,
    quad_decoder_if.slave  bus
);
    localparam int unsigned CNT_W = DEBOUNCE_N;
    localparam logic signed [3:0] STEPS = 4'(STEPS_PER_PULSE);

    logic [1:0]       s1, s2;
    logic [1:0]       db, db_nxt;
    logic [1:0]       prev;
    logic [CNT_W-1:0] cnt [2];
    logic [CNT_W-1:0] cnt_nxt [2];
    logic signed [3:0] sub, sub_step, sub_nxt;
    logic             cw_q, ccw_q, err_q;
    logic             cw_nxt, ccw_nxt, err_nxt;

    // Next position on the clockwise ring 01 -> 11 -> 10 -> 00 -> 01.
    function automatic logic [1:0] cw_next(input logic [1:0] p);
        case (p)
            2'b01:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b10;
            2'b10:   cw_next = 2'b00;
            default: cw_next = 2'b01;
        endcase
    endfunction

    // Synchroniser runs through reset so db can track the pins while held.
    always_ff @(posedge clk) begin
        s1 <= {bus.a, bus.b};
        s2 <= s1;
    end

    // Debounce: commit only after 2^N consecutive differing samples.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < 2; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == '1) db_nxt[i] = s2[i];
                else              cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Phase decode and sub-step accumulation.
    always_comb begin
        sub_step = sub;
        sub_nxt  = sub;
        cw_nxt   = 1'b0;
        ccw_nxt  = 1'b0;
        err_nxt  = 1'b0;
        if (db != prev) begin
            if (db == cw_next(prev))      sub_step = sub + 4'sd1;
            else if (prev == cw_next(db)) sub_step = sub - 4'sd1;
            else                          err_nxt  = 1'b1;
        end
        if (err_nxt) begin
            sub_nxt = '0;
        end else if (sub_step == STEPS) begin
            cw_nxt  = 1'b1;
            sub_nxt = '0;
        end else if (sub_step == -STEPS) begin
            ccw_nxt = 1'b1;
            sub_nxt = '0;
        end else begin
            sub_nxt = sub_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            db     <= s2;
            prev   <= s2;
            cnt[0] <= '0;
            cnt[1] <= '0;
            sub    <= '0;
            cw_q   <= 1'b0;
            ccw_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            db     <= db_nxt;
            prev   <= db;
            cnt[0] <= cnt_nxt[0];
            cnt[1] <= cnt_nxt[1];
            sub    <= sub_nxt;
            cw_q   <= cw_nxt;
            ccw_q  <= ccw_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.ab_db    = db;
    assign bus.step_cw  = cw_q;
    assign bus.step_ccw = ccw_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: two instances (4 and 1 sub-steps per pulse) share the pins.
module tb_quad_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quad_decoder_if bus4 ();
    quad_decoder_if bus1 ();

    assign bus4.a = a;
    assign bus4.b = b;
    assign bus1.a = a;
    assign bus1.b = b;

    quad_decoder #(.DEBOUNCE_N(2), .STEPS_PER_PULSE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    quad_decoder #(.DEBOUNCE_N(2), .STEPS_PER_PULSE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [1:0] ab;
        int cw4, ccw4, er4, cw1, ccw1, er1;
    } exp_t;

    exp_t sb[$];

    int t_cw4 = 0, t_ccw4 = 0, t_er4 = 0, t_cw1 = 0, t_ccw1 = 0, t_er1 = 0;
    int s_cw4, s_ccw4, s_er4, s_cw1, s_ccw1, s_er1;
    int cyc = 0;
    int chg_cyc = 0;
    logic [1:0] last_db = 2'b01;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulse totals, exclusivity and decode latency relative to ab_db commits.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        t_cw4  <= t_cw4  + 32'(bus4.step_cw);
        t_ccw4 <= t_ccw4 + 32'(bus4.step_ccw);
        t_er4  <= t_er4  + 32'(bus4.err);
        t_cw1  <= t_cw1  + 32'(bus1.step_cw);
        t_ccw1 <= t_ccw1 + 32'(bus1.step_ccw);
        t_er1  <= t_er1  + 32'(bus1.err);
        if (bus4.ab_db != last_db) begin
            last_db <= bus4.ab_db;
            chg_cyc <= cyc;
        end
        if (bus4.step_cw || bus4.step_ccw || bus4.err) begin
            chk("excl4", 32'($countones({bus4.step_cw, bus4.step_ccw, bus4.err})), 1);
            chk("lat4", 32'(cyc - chg_cyc), 1);
        end
        if (bus1.step_cw || bus1.step_ccw || bus1.err) begin
            chk("excl1", 32'($countones({bus1.step_cw, bus1.step_ccw, bus1.err})), 1);
            chk("lat1", 32'(cyc - chg_cyc), 1);
        end
    end

    task automatic start_win(input exp_t e);
        sb.push_back(e);
        s_cw4 = t_cw4; s_ccw4 = t_ccw4; s_er4 = t_er4;
        s_cw1 = t_cw1; s_ccw1 = t_ccw1; s_er1 = t_er1;
    endtask

    task automatic end_win(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".ab4"},  32'(bus4.ab_db), 32'(e.ab));
        chk({tag, ".ab1"},  32'(bus1.ab_db), 32'(e.ab));
        chk({tag, ".cw4"},  32'(t_cw4  - s_cw4),  32'(e.cw4));
        chk({tag, ".ccw4"}, 32'(t_ccw4 - s_ccw4), 32'(e.ccw4));
        chk({tag, ".err4"}, 32'(t_er4  - s_er4),  32'(e.er4));
        chk({tag, ".cw1"},  32'(t_cw1  - s_cw1),  32'(e.cw1));
        chk({tag, ".ccw1"}, 32'(t_ccw1 - s_ccw1), 32'(e.ccw1));
        chk({tag, ".err1"}, 32'(t_er1  - s_er1),  32'(e.er1));
    endtask

    // Drive a new pin level, hold 10 cycles, compare against expected pulse counts.
    task automatic phase(input string tag, input logic na, input logic nb,
                         input int cw4, input int ccw4, input int er4,
                         input int cw1, input int ccw1, input int er1);
        exp_t e;
        @(negedge clk);
        e = '{ab: {na, nb}, cw4: cw4, ccw4: ccw4, er4: er4, cw1: cw1, ccw1: ccw1, er1: er1};
        start_win(e);
        a = na;
        b = nb;
        repeat (10) @(negedge clk);
        end_win(tag);
    endtask

    initial begin
        exp_t e;
        // Reset with a=0, b=1
        repeat (3) @(negedge clk);
        chk("rst.ab", 32'(bus4.ab_db), 32'(2'b01));
        chk("rst.cw", 32'(bus4.step_cw), 0);
        chk("rst.ccw", 32'(bus4.step_ccw), 0);
        chk("rst.err", 32'(bus4.err), 0);
        rst = 1'b1;
        phase("idle0", 0, 1, 0, 0, 0, 0, 0, 0);
        phase("idle1", 0, 1, 0, 0, 0, 0, 0, 0);

        // One CW step
        phase("cw0", 1, 1, 0, 0, 0, 1, 0, 0);
        phase("cw1", 1, 0, 0, 0, 0, 1, 0, 0);
        phase("cw2", 0, 0, 0, 0, 0, 1, 0, 0);
        phase("cw3", 0, 1, 1, 0, 0, 1, 0, 0);

        // One CCW step
        phase("ccw0", 0, 0, 0, 0, 0, 0, 1, 0);
        phase("ccw1", 1, 0, 0, 0, 0, 0, 1, 0);
        phase("ccw2", 1, 1, 0, 0, 0, 0, 1, 0);
        phase("ccw3", 0, 1, 0, 1, 0, 0, 1, 0);

        // Glitch rejection on a
        @(negedge clk);
        e = '{ab: 2'b01, cw4: 0, ccw4: 0, er4: 0, cw1: 0, ccw1: 0, er1: 0};
        start_win(e);
        repeat (20) begin
            a = ~a;
            repeat (2) @(negedge clk);
        end
        a = 1'b0;
        repeat (10) @(negedge clk);
        end_win("glitch");

        // Illegal jump must discard a partial step
        phase("pre", 1, 1, 0, 0, 0, 1, 0, 0);
        phase("jmp0", 0, 0, 0, 0, 1, 0, 0, 1);
        phase("r0", 0, 1, 0, 0, 0, 1, 0, 0);
        phase("r1", 1, 1, 0, 0, 0, 1, 0, 0);
        phase("r2", 1, 0, 0, 0, 0, 1, 0, 0);
        phase("r3", 0, 0, 1, 0, 0, 1, 0, 0);
        phase("r4", 0, 1, 0, 0, 0, 1, 0, 0);
        phase("jmp1", 1, 0, 0, 0, 1, 0, 0, 1);
        // Reversal mid-step
        phase("rev0", 0, 0, 0, 0, 0, 1, 0, 0);
        phase("rev1", 0, 1, 0, 0, 0, 1, 0, 0);
        phase("rev2", 0, 0, 0, 0, 0, 0, 1, 0);
        phase("rev3", 1, 0, 0, 0, 0, 0, 1, 0);

        // Partial step then reset abort
        phase("ab0", 0, 0, 0, 0, 0, 1, 0, 0);
        phase("ab1", 0, 1, 0, 0, 0, 1, 0, 0);
        phase("ab2", 1, 1, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        e = '{ab: 2'b11, cw4: 0, ccw4: 0, er4: 0, cw1: 0, ccw1: 0, er1: 0};
        start_win(e);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        end_win("rstab");
        phase("post0", 1, 0, 0, 0, 0, 1, 0, 0);
        phase("post1", 0, 0, 0, 0, 0, 1, 0, 0);
        phase("post2", 0, 1, 0, 0, 0, 1, 0, 0);
        phase("post3", 1, 1, 1, 0, 0, 1, 0, 0);

        chk("sb.empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
